// File: rtl/vga_console_pkg.sv
// rtl/vga_console_pkg.sv - shared encodings and constants for the VGA text-console sequencer
package vga_console_pkg;

    typedef enum logic [1:0] {
        OP_PUTC      = 2'd0,
        OP_CLEAR     = 2'd1,
        OP_SETPOS    = 2'd2,
        OP_CURSOR_EN = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT_WR,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_CLR_WR,
        ST_CUR_EN,
        ST_CUR_ROW,
        ST_CUR_COL
    } state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    localparam logic [31:0] CUR_EN_OFS  = 32'h0;
    localparam logic [31:0] CUR_ROW_OFS = 32'h4;
    localparam logic [31:0] CUR_COL_OFS = 32'h8;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/vga_bus_master.sv
// rtl/vga_bus_master.sv - single-word request/ack engine driving the VGA device bus
module vga_bus_master (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        cs_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i
);

    // Request fields are latched on start and held until ack; ack with cs low is ignored.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cs_o    <= 1'b0;
            we_o    <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
            done_o  <= 1'b0;
            rdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (cs_o) begin
                if (ack_i) begin
                    cs_o   <= 1'b0;
                    we_o   <= 1'b0;
                    done_o <= 1'b1;
                    if (!we_o) begin
                        rdata_o <= data_i;
                    end
                end
            end else if (start_i) begin
                cs_o   <= 1'b1;
                we_o   <= we_i;
                addr_o <= addr_i;
                data_o <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/vga_console_ctrl.sv
// rtl/vga_console_ctrl.sv - console command sequencer: cursor tracking, scroll, clear, cursor regs
module vga_console_ctrl
    import vga_console_pkg::*;
#(
    parameter int          COLS        = 80,
    parameter int          ROWS        = 30,
    parameter logic [31:0] CURSOR_BASE = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [15:0] cmd_data_i,
    output logic        busy_o,
    output logic        cs_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i,
    output logic [7:0]  cur_row_o,
    output logic [7:0]  cur_col_o
);

    localparam logic [12:0] COLS13        = 13'(COLS);
    localparam logic [12:0] CELLS_LAST    = 13'(COLS * ROWS - 1);
    localparam logic [12:0] LAST_ROW_BASE = 13'((ROWS - 1) * COLS);
    localparam logic [7:0]  COL_MAX       = 8'(COLS - 1);
    localparam logic [7:0]  ROW_MAX       = 8'(ROWS - 1);

    state_e      state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic [12:0] idx_q, idx_d;
    logic [7:0]  ch_q, ch_d;
    logic        en_q, en_d;
    logic        advance_q, advance_d;
    logic        clear_scr_q, clear_scr_d;
    logic        issued_q, issued_d;

    logic        bm_start;
    logic        bm_we;
    logic [31:0] bm_addr;
    logic [31:0] bm_wdata;
    logic        bm_done;
    logic [31:0] bm_rdata;
    logic [12:0] cell_addr;
    logic        unused_rdata_hi;

    assign cell_addr       = 13'(row_q) * COLS13 + 13'(col_q);
    assign cmd_ready_o     = (state_q == ST_IDLE) && !reset_i;
    assign busy_o          = (state_q != ST_IDLE);
    assign cur_row_o       = row_q;
    assign cur_col_o       = col_q;
    assign unused_rdata_hi = ^bm_rdata[31:8];

    vga_bus_master u_bus (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (bm_start),
        .we_i    (bm_we),
        .addr_i  (bm_addr),
        .wdata_i (bm_wdata),
        .done_o  (bm_done),
        .rdata_o (bm_rdata),
        .cs_o    (cs_o),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .data_i  (data_i),
        .ack_i   (ack_i)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            idx_q       <= '0;
            ch_q        <= '0;
            en_q        <= 1'b0;
            advance_q   <= 1'b0;
            clear_scr_q <= 1'b0;
            issued_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            idx_q       <= idx_d;
            ch_q        <= ch_d;
            en_q        <= en_d;
            advance_q   <= advance_d;
            clear_scr_q <= clear_scr_d;
            issued_q    <= issued_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        idx_d       = idx_q;
        ch_d        = ch_q;
        en_d        = en_q;
        advance_d   = advance_q;
        clear_scr_d = clear_scr_q;
        issued_d    = issued_q;
        bm_start    = 1'b0;
        bm_we       = 1'b1;
        bm_addr     = '0;
        bm_wdata    = '0;

        case (state_q)
            ST_PUT_WR: begin
                bm_addr  = {19'b0, cell_addr};
                bm_wdata = {24'b0, ch_q};
            end
            ST_SCR_RD: begin
                bm_we   = 1'b0;
                bm_addr = {19'b0, idx_q};
            end
            ST_SCR_WR: begin
                bm_addr  = {19'b0, idx_q - COLS13};
                bm_wdata = {24'b0, bm_rdata[7:0]};
            end
            ST_CLR_WR: begin
                bm_addr  = {19'b0, idx_q};
                bm_wdata = {24'b0, ASCII_SPACE};
            end
            ST_CUR_EN: begin
                bm_addr  = CURSOR_BASE + CUR_EN_OFS;
                bm_wdata = {31'b0, en_q};
            end
            ST_CUR_ROW: begin
                bm_addr  = CURSOR_BASE + CUR_ROW_OFS;
                bm_wdata = {24'b0, row_q};
            end
            ST_CUR_COL: begin
                bm_addr  = CURSOR_BASE + CUR_COL_OFS;
                bm_wdata = {24'b0, col_q};
            end
            default: ;
        endcase

        // One bus request per state visit (or per cell index in the loop states).
        if (state_q != ST_IDLE && !issued_q) begin
            bm_start = 1'b1;
            issued_d = 1'b1;
        end
        if (bm_done) begin
            issued_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    case (op_e'(cmd_op_i))
                        OP_PUTC: begin
                            ch_d      = cmd_data_i[7:0];
                            advance_d = 1'b1;
                            state_d   = ST_CUR_ROW;
                            if (is_printable(cmd_data_i[7:0])) begin
                                state_d = ST_PUT_WR;
                            end else if (cmd_data_i[7:0] == ASCII_LF) begin
                                col_d = '0;
                                if (row_q == ROW_MAX) begin
                                    idx_d       = COLS13;
                                    clear_scr_d = 1'b0;
                                    state_d     = ST_SCR_RD;
                                end else begin
                                    row_d = row_q + 8'd1;
                                end
                            end else if (cmd_data_i[7:0] == ASCII_CR) begin
                                col_d = '0;
                            end else if (cmd_data_i[7:0] == ASCII_BS && col_q != 8'd0) begin
                                col_d     = col_q - 8'd1;
                                ch_d      = ASCII_SPACE;
                                advance_d = 1'b0;
                                state_d   = ST_PUT_WR;
                            end
                        end
                        OP_CLEAR: begin
                            idx_d       = '0;
                            clear_scr_d = 1'b1;
                            state_d     = ST_CLR_WR;
                        end
                        OP_SETPOS: begin
                            row_d   = (cmd_data_i[15:8] > ROW_MAX) ? ROW_MAX : cmd_data_i[15:8];
                            col_d   = (cmd_data_i[7:0] > COL_MAX) ? COL_MAX : cmd_data_i[7:0];
                            state_d = ST_CUR_ROW;
                        end
                        default: begin
                            en_d    = cmd_data_i[0];
                            state_d = ST_CUR_EN;
                        end
                    endcase
                end
            end
            ST_PUT_WR: begin
                if (bm_done) begin
                    state_d = ST_CUR_ROW;
                    if (advance_q) begin
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            if (row_q == ROW_MAX) begin
                                idx_d       = COLS13;
                                clear_scr_d = 1'b0;
                                state_d     = ST_SCR_RD;
                            end else begin
                                row_d = row_q + 8'd1;
                            end
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                    end
                end
            end
            ST_SCR_RD: begin
                if (bm_done) begin
                    state_d = ST_SCR_WR;
                end
            end
            ST_SCR_WR: begin
                if (bm_done) begin
                    if (idx_q == CELLS_LAST) begin
                        idx_d   = LAST_ROW_BASE;
                        state_d = ST_CLR_WR;
                    end else begin
                        idx_d   = idx_q + 13'd1;
                        state_d = ST_SCR_RD;
                    end
                end
            end
            ST_CLR_WR: begin
                if (bm_done) begin
                    if (idx_q == CELLS_LAST) begin
                        state_d = ST_CUR_ROW;
                        if (clear_scr_q) begin
                            row_d = '0;
                            col_d = '0;
                        end else begin
                            row_d = ROW_MAX;
                        end
                    end else begin
                        idx_d = idx_q + 13'd1;
                    end
                end
            end
            ST_CUR_EN: begin
                if (bm_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CUR_ROW: begin
                if (bm_done) begin
                    state_d = ST_CUR_COL;
                end
            end
            ST_CUR_COL: begin
                if (bm_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// tb/tb_vga_console_ctrl.sv - directed, table-driven bench for vga_console_ctrl
module tb_vga_console_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = 2'd0;
    logic [15:0] cmd_data_i = 16'd0;
    logic        busy_o;
    logic        cs_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i = 32'd0;
    logic        ack_i = 1'b0;
    logic [7:0]  cur_row_o;
    logic [7:0]  cur_col_o;

    always #5 clk = ~clk;

    vga_console_ctrl dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_data_i  (cmd_data_i),
        .busy_o      (busy_o),
        .cs_o        (cs_o),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .data_i      (data_i),
        .ack_i       (ack_i),
        .cur_row_o   (cur_row_o),
        .cur_col_o   (cur_col_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Device model: byte-wide cell memory, programmable ack latency, transaction log.
    logic [7:0]  mem [0:8191];
    logic [7:0]  pre [0:2399];
    logic        tx_we[$];
    logic [31:0] tx_addr[$];
    logic [31:0] tx_data[$];
    int          ack_delay = 2;
    int          wait_cnt = 0;
    int          stab_err = 0;
    int          gap_err = 0;
    logic [31:0] req_addr, req_data;
    logic        req_we;

    always @(negedge clk) begin
        if (ack_i) begin
            ack_i = 1'b0;
            wait_cnt = 0;
            if (cs_o && !reset_i) gap_err++;
        end else if (cs_o) begin
            if (wait_cnt == 0) begin
                req_addr = addr_o;
                req_data = data_o;
                req_we   = we_o;
            end else if (addr_o !== req_addr || data_o !== req_data || we_o !== req_we) begin
                stab_err++;
            end
            if (wait_cnt >= ack_delay) begin
                tx_we.push_back(we_o);
                tx_addr.push_back(addr_o);
                tx_data.push_back(data_o);
                if (we_o) begin
                    if (addr_o < 32'h2000) mem[addr_o[12:0]] = data_o[7:0];
                end else begin
                    data_i = {24'b0, mem[addr_o[12:0]]};
                end
                ack_i = 1'b1;
            end
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    end

    function automatic logic [31:0] txa(input int k);
        return (k < tx_addr.size()) ? tx_addr[k] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] txd(input int k);
        return (k < tx_data.size()) ? tx_data[k] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic txw(input int k);
        return (k < tx_we.size()) ? tx_we[k] : 1'bx;
    endfunction
    function automatic int n_cells();
        int n = 0;
        foreach (tx_addr[k]) if (tx_we[k] && tx_addr[k] < 32'h2000) n++;
        return n;
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] d);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        tx_we.delete();
        tx_addr.delete();
        tx_data.delete();
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_data_i  = d;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        check("busy_after_accept", {31'b0, busy_o}, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy_o && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("idle_within_budget", {31'b0, busy_o}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        int          n_tx;
        int          n_cell;
        logic [31:0] f_addr;
        logic [31:0] f_data;
        logic [31:0] l_addr;
        logic [31:0] l_data;
        logic [7:0]  row;
        logic [7:0]  col;
    } vec_t;

    vec_t vecs[16];
    int   errs;
    int   t;

    initial begin
        vecs[0]  = '{2'd2, 16'h050A, 2, 0, 32'h2004, 32'd5,    32'h2008, 32'd10, 8'd5,  8'd10};
        vecs[1]  = '{2'd0, 16'h000A, 2, 0, 32'h2004, 32'd6,    32'h2008, 32'd0,  8'd6,  8'd0};
        vecs[2]  = '{2'd0, 16'h0008, 2, 0, 32'h2004, 32'd6,    32'h2008, 32'd0,  8'd6,  8'd0};
        vecs[3]  = '{2'd2, 16'h0203, 2, 0, 32'h2004, 32'd2,    32'h2008, 32'd3,  8'd2,  8'd3};
        vecs[4]  = '{2'd0, 16'h0008, 3, 1, 32'd162,  32'h20,   32'h2008, 32'd2,  8'd2,  8'd2};
        vecs[5]  = '{2'd0, 16'h000D, 2, 0, 32'h2004, 32'd2,    32'h2008, 32'd0,  8'd2,  8'd0};
        vecs[6]  = '{2'd0, 16'h0001, 2, 0, 32'h2004, 32'd2,    32'h2008, 32'd0,  8'd2,  8'd0};
        vecs[7]  = '{2'd0, 16'h007E, 3, 1, 32'd160,  32'h7E,   32'h2008, 32'd1,  8'd2,  8'd1};
        vecs[8]  = '{2'd0, 16'h0020, 3, 1, 32'd161,  32'h20,   32'h2008, 32'd2,  8'd2,  8'd2};
        vecs[9]  = '{2'd2, 16'hC8C8, 2, 0, 32'h2004, 32'd29,   32'h2008, 32'd79, 8'd29, 8'd79};
        vecs[10] = '{2'd3, 16'h0001, 1, 0, 32'h2000, 32'd1,    32'h2000, 32'd1,  8'd29, 8'd79};
        vecs[11] = '{2'd2, 16'h004F, 2, 0, 32'h2004, 32'd0,    32'h2008, 32'd79, 8'd0,  8'd79};
        vecs[12] = '{2'd0, 16'h0043, 3, 1, 32'd79,   32'h43,   32'h2008, 32'd0,  8'd1,  8'd0};
        vecs[13] = '{2'd0, 16'h007F, 2, 0, 32'h2004, 32'd1,    32'h2008, 32'd0,  8'd1,  8'd0};
        vecs[14] = '{2'd3, 16'h0000, 1, 0, 32'h2000, 32'd0,    32'h2000, 32'd0,  8'd1,  8'd0};
        vecs[15] = '{2'd2, 16'h1E50, 2, 0, 32'h2004, 32'd29,   32'h2008, 32'd79, 8'd29, 8'd79};

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", {31'b0, cs_o}, 32'd0);
        check("rst_we", {31'b0, we_o}, 32'd0);
        check("rst_addr", addr_o, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_row", {24'b0, cur_row_o}, 32'd0);
        check("rst_col", {24'b0, cur_col_o}, 32'd0);
        check("rst_ready_in_reset", {31'b0, cmd_ready_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("ready_after_reset", {31'b0, cmd_ready_o}, 32'd1);

        // First PUTC with slow ack
        send_cmd(2'd0, 16'h0041);
        wait_idle(200);
        check("a_ntx", tx_addr.size(), 32'd3);
        check("a_tx0_we", {31'b0, txw(0)}, 32'd1);
        check("a_tx0_addr", txa(0), 32'd0);
        check("a_tx0_data", txd(0), 32'h41);
        check("a_tx1_addr", txa(1), 32'h2004);
        check("a_tx1_data", txd(1), 32'd0);
        check("a_tx2_addr", txa(2), 32'h2008);
        check("a_tx2_data", txd(2), 32'd1);
        check("a_row", {24'b0, cur_row_o}, 32'd0);
        check("a_col", {24'b0, cur_col_o}, 32'd1);

        // Table of single commands
        ack_delay = 1;
        for (int i = 0; i < 16; i++) begin
            send_cmd(vecs[i].op, vecs[i].data);
            wait_idle(200);
            check($sformatf("v%0d_ntx", i), tx_addr.size(), vecs[i].n_tx);
            check($sformatf("v%0d_ncell", i), n_cells(), vecs[i].n_cell);
            check($sformatf("v%0d_first_addr", i), txa(0), vecs[i].f_addr);
            check($sformatf("v%0d_first_data", i), txd(0), vecs[i].f_data);
            check($sformatf("v%0d_last_addr", i), txa(vecs[i].n_tx - 1), vecs[i].l_addr);
            check($sformatf("v%0d_last_data", i), txd(vecs[i].n_tx - 1), vecs[i].l_data);
            check($sformatf("v%0d_row", i), {24'b0, cur_row_o}, {24'b0, vecs[i].row});
            check($sformatf("v%0d_col", i), {24'b0, cur_col_o}, {24'b0, vecs[i].col});
        end

        // Scroll triggered by a character at the bottom-right cell
        ack_delay = 0;
        for (int i = 0; i < 2400; i++) mem[i] = 8'((i * 7 + 3) & 8'hFF);
        send_cmd(2'd2, 16'h1D4F);
        wait_idle(200);
        for (int i = 0; i < 2400; i++) pre[i] = mem[i];
        pre[2399] = 8'h42;
        send_cmd(2'd0, 16'h0042);
        wait_idle(40000);
        check("s_ntx", tx_addr.size(), 32'd4723);
        check("s_put_addr", txa(0), 32'd2399);
        check("s_put_data", txd(0), 32'h42);
        check("s_rd0_we", {31'b0, txw(1)}, 32'd0);
        check("s_rd0_addr", txa(1), 32'd80);
        check("s_wr0_addr", txa(2), 32'd0);
        check("s_wr0_data", txd(2), {24'b0, pre[80]});
        check("s_wr_last_addr", txa(4640), 32'd2319);
        check("s_wr_last_data", txd(4640), 32'h42);
        errs = 0;
        for (int k = 0; k < 2320; k++) begin
            if (txw(1 + 2 * k) !== 1'b0 || txa(1 + 2 * k) !== 32'(80 + k)) errs++;
            if (txw(2 + 2 * k) !== 1'b1 || txa(2 + 2 * k) !== 32'(k) ||
                txd(2 + 2 * k) !== {24'b0, pre[80 + k]}) errs++;
        end
        check("s_copy_order_errs", errs, 32'd0);
        check("s_clr_first_addr", txa(4641), 32'd2320);
        check("s_clr_first_data", txd(4641), 32'h20);
        check("s_clr_last_addr", txa(4720), 32'd2399);
        check("s_cur_row_addr", txa(4721), 32'h2004);
        check("s_cur_row_data", txd(4721), 32'd29);
        check("s_cur_col_addr", txa(4722), 32'h2008);
        check("s_cur_col_data", txd(4722), 32'd0);
        errs = 0;
        for (int k = 0; k < 2320; k++) if (mem[k] !== pre[k + 80]) errs++;
        for (int k = 2320; k < 2400; k++) if (mem[k] !== 8'h20) errs++;
        check("s_screen_errs", errs, 32'd0);
        check("s_row", {24'b0, cur_row_o}, 32'd29);
        check("s_col", {24'b0, cur_col_o}, 32'd0);

        // Full clear
        send_cmd(2'd1, 16'h0000);
        wait_idle(30000);
        check("c_ntx", tx_addr.size(), 32'd2402);
        errs = 0;
        for (int k = 0; k < 2400; k++) begin
            if (txw(k) !== 1'b1 || txa(k) !== 32'(k) || txd(k) !== 32'h20) errs++;
        end
        check("c_cell_errs", errs, 32'd0);
        check("c_cur_row_addr", txa(2400), 32'h2004);
        check("c_cur_row_data", txd(2400), 32'd0);
        check("c_cur_col_addr", txa(2401), 32'h2008);
        check("c_cur_col_data", txd(2401), 32'd0);
        check("c_row", {24'b0, cur_row_o}, 32'd0);
        check("c_col", {24'b0, cur_col_o}, 32'd0);

        // Reset in the middle of a clear
        send_cmd(2'd2, 16'h0404);
        wait_idle(200);
        check("m_pre_row", {24'b0, cur_row_o}, 32'd4);
        send_cmd(2'd1, 16'h0000);
        t = 0;
        while (!(cs_o && addr_o == 32'd1000) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("m_reached_cell_1000", addr_o, 32'd1000);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        check("m_cs_after_reset", {31'b0, cs_o}, 32'd0);
        check("m_busy_after_reset", {31'b0, busy_o}, 32'd0);
        check("m_row_after_reset", {24'b0, cur_row_o}, 32'd0);
        check("m_col_after_reset", {24'b0, cur_col_o}, 32'd0);
        check("m_ready_in_reset", {31'b0, cmd_ready_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("m_ready_after_release", {31'b0, cmd_ready_o}, 32'd1);
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cs_o || busy_o) errs++;
        end
        check("m_not_resumed", errs, 32'd0);

        // Normal operation after the abandoned clear
        send_cmd(2'd0, 16'h0041);
        wait_idle(200);
        check("r_ntx", tx_addr.size(), 32'd3);
        check("r_put_addr", txa(0), 32'd0);
        check("r_put_data", txd(0), 32'h41);
        check("r_row", {24'b0, cur_row_o}, 32'd0);
        check("r_col", {24'b0, cur_col_o}, 32'd1);

        check("bus_stable_until_ack", stab_err, 32'd0);
        check("cs_gap_after_ack", gap_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_console_ctrl.md
# vga_console_ctrl

Text-console sequencer in front of the VGA character device. It accepts one-cycle console commands from the CPU side: put character, clear screen, set cursor position. It turns each command into the ordered sequence of single-word bus transactions the VGA device needs, covering character writes, full-screen scroll, screen clear and cursor register updates. It owns the logical cursor position and runs entirely in the bus clock domain.

## Interface
- `COLS`, 80: characters per row.
- `ROWS`, 30: rows per screen.
- `CURSOR_BASE`, 32'h0000_2000: device address of cursor regs (+0 enable, +4 row, +8 col).
- `clk_i`  in  1  bus clock. One clock; reset is synchronous and active-high.
- `reset_i`  in  1  synchronous, active-high reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when valid&ready.
- `cmd_op_i`  in  2  0=PUTC, 1=CLEAR, 2=SETPOS, 3=CURSOR_EN.
- `cmd_data_i`  in  16  PUTC: [7:0] ASCII; SETPOS: [15:8] row, [7:0] col; CURSOR_EN: [0].
- `busy_o`  out  1  sequence in progress.
- `cs_o`  out  1  device select.
- `we_o`  out  1  write enable.
- `addr_o`  out  32  device address; character cell = row*COLS+col in [12:0], upper bits 0.
- `data_o`  out  32  write data, char in [7:0], rest 0.
- `data_i`  in  32  device read data, valid with `ack_i`.
- `ack_i`  in  1  transaction complete.
- `cur_row_o`, `cur_col_o`  out  8  logical cursor.

## Operation
- States: IDLE, PUT_WR, SCR_RD, SCR_WR, CLR_WR, CUR_EN, CUR_ROW, CUR_COL.
- `cmd_ready_o` = (state==IDLE) & ~reset_i. `busy_o` = state!=IDLE.
- PUTC printable (0x20–0x7E): PUT_WR writes char at cursor. col+1. If col reaches COLS: col=0, row+1.
- PUTC 0x0A: col=0, row+1, no char write.
- PUTC 0x0D: col=0.
- PUTC 0x08: if col>0, col-1 and write 0x20 there; else no-op.
- Other codes are ignored, but the cursor update still runs.
- Row overflow (row would become ROWS): run a scroll. For i = COLS to COLS*ROWS-1: SCR_RD reads cell i, then SCR_WR writes that data to cell i-COLS. Then CLR_WR writes 0x20 to the last row. row=ROWS-1.
- CLEAR: CLR_WR writes 0x20 to cells 0..COLS*ROWS-1 ascending, then cursor=(0,0).
- SETPOS: row clamped to ROWS-1, col clamped to COLS-1. No cell access.
- CURSOR_EN: single write of data[0] to CURSOR_BASE, then IDLE.
- Every PUTC/CLEAR/SETPOS ends with CUR_ROW (write row to CURSOR_BASE+4), then CUR_COL (write col to +8), then IDLE.
- Cell index arithmetic is 13-bit, computed as row*COLS+col from registered row/col. No overflow for the default parameters.

## Timing
- Reset values: state IDLE, `cs_o`=0, `we_o`=0, `addr_o`=0, `data_o`=0, cursor (0,0), `busy_o`=0.
- Bus handshake:
  - `cs_o`, `we_o`, `addr_o` and `data_o` are registered. They are driven in the cycle after state entry and held stable until `ack_i` is sampled high.
  - `cs_o` drops in the cycle after ack for one cycle minimum before the next transaction.
  - Read data is captured on the ack cycle.
- `ack_i` while `cs_o`=0 is ignored.
- Command acceptance to `busy_o` high: 1 cycle.
- Printable PUTC without scroll issues exactly 3 transactions. SETPOS issues 2.
- Scroll issues 2*COLS*(ROWS-1)+COLS transactions, then 2 cursor writes.
- No command is accepted while busy. `cmd_valid_i` may be held; it is consumed on the first IDLE cycle.
- Reset mid-sequence: next cycle is IDLE, `cs_o`=0, cursor (0,0). A partial scroll/clear is abandoned and not resumed.

## Structure
- Shared package `vga_console_pkg`: op encodings, state enum, ASCII constants (SPACE, LF, CR, BS), cursor register offsets.
- One sub-module `vga_bus_master`: the single-transaction request/ack engine (start, we, addr, wdata → done, rdata). The FSM and cursor arithmetic stay in the top.

## Test plan
- Reset, then PUTC 0x41 with ack after 2 cycles: write 0x41 @0, write 0 @0x2004, write 1 @0x2008; cursor (0,1); `busy_o` low afterwards.
- SETPOS row=29, col=79, then PUTC 0x42: 0x42 written @2399. Scroll follows: first read @80, write @0, …; last row cleared @2320–2399; cursor (29,0).
- PUTC 0x0A at (5,10) → cursor (6,0), no cell write. PUTC 0x08 at (6,0) → no cell write, cursor unchanged.
- CLEAR: 2400 writes of 0x20 at addresses 0..2399 ascending, then cursor writes (0,0).
- SETPOS row=200, col=200 → cursor (29,79), zero cell writes.
- Assert `reset_i` mid-CLEAR at cell 1000 → `cs_o`=0 the next cycle, cursor (0,0). `cmd_ready_o` returns high the cycle after reset deasserts.
